ts_table_mux: RTL and testbench
===============================

Name: ts_table_mux

Overview:
- Merges the periodic PSI table packets from insert_tables (PAT/PMT/SDT) with the main T2-MI TS packet stream.
- Produces one continuous 188-byte TS byte stream for the output interface.
- Arbitrates only at packet boundaries; table packets have priority.
- Holds the T2-MI packer off through a ready handshake while a table packet is in flight.
- Drives START to insert_tables and consumes its TABLE_READY, TABLE_SENT, DATA_OUT and ENA_OUT.

Parameters:
- PKT_LEN, 188, TS packet length in bytes.
- TABLE_TIMEOUT, 1024, cycles without TABLE_SENT before a table transfer is aborted.
- NULL_GAP, 4096, idle cycles before a null packet is emitted (used only with NULL_PACKET_EN).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- T2MI_DATA  in  8  T2-MI TS byte.
- T2MI_ENA  in  1  T2MI_DATA valid.
- T2MI_SOP  in  1  marks the first byte (0x47) of a T2-MI packet.
- T2MI_READY  out  1  mux accepts a T2-MI byte this cycle.
- TABLE_READY  in  1  a table packet is pending (from insert_tables).
- TABLE_DATA  in  8  table packet byte (insert_tables DATA_OUT).
- TABLE_ENA  in  1  TABLE_DATA valid (insert_tables ENA_OUT).
- TABLE_SENT  in  1  one-cycle pulse after the last table byte.
- TABLE_START  out  1  one-cycle pulse that starts a table packet (insert_tables START).
- DATA_OUT  out  8  merged TS byte.
- ENA_OUT  out  1  DATA_OUT valid.
- SOP_OUT  out  1  first byte of an output packet.
- PKT_ERR  out  1  one-cycle error pulse.
- state_mon  out  2  current FSM state, for debug.

Behaviour:
- Reset values: DATA_OUT=0, ENA_OUT=0, SOP_OUT=0, T2MI_READY=0, TABLE_START=0, PKT_ERR=0, state=IDLE, all counters 0. Reset mid-packet abandons the packet; no resume.
- Latency: all outputs registered. An accepted input byte appears on DATA_OUT/ENA_OUT exactly 1 cycle later.
- Input handshake: a T2-MI byte transfers when T2MI_ENA && T2MI_READY. The upstream holds the byte while T2MI_READY=0.
- The table path has no backpressure. Every TABLE_ENA byte is forwarded; ENA gaps pass through unchanged.
- FSM states: IDLE=0, T2MI=1, TABLE=2, NULL=3.
- IDLE, priority 1: if TABLE_READY=1, pulse TABLE_START, drive T2MI_READY=0 this cycle, go to TABLE, clear byte_cnt and timeout counter.
- IDLE, priority 2: otherwise T2MI_READY=1. An accepted byte with T2MI_SOP=1 is forwarded with SOP_OUT=1, byte_cnt=1, next state T2MI.
- IDLE, priority 3: an accepted byte with T2MI_SOP=0 is dropped and pulses PKT_ERR; state stays IDLE.
- T2MI: T2MI_READY=1. Each accepted byte is forwarded and increments byte_cnt.
- T2MI: when byte_cnt reaches PKT_LEN, go to IDLE. T2MI_READY=0 in that IDLE entry cycle is not required; the next packet may start immediately.
- T2MI: an accepted byte with SOP=1 while byte_cnt<PKT_LEN pulses PKT_ERR. That byte starts a new packet (SOP_OUT=1, byte_cnt=1), so the truncated packet goes out as-is.
- TABLE: T2MI_READY=0. TABLE_ENA bytes are forwarded, byte_cnt increments, and SOP_OUT=1 on the first table byte.
- TABLE: on TABLE_SENT, go to IDLE. If byte_cnt != PKT_LEN, also pulse PKT_ERR.
- TABLE timeout: the counter increments every cycle in TABLE. When it reaches TABLE_TIMEOUT, go to IDLE and pulse PKT_ERR. TABLE_ENA bytes arriving afterwards, outside TABLE, are ignored.
- Simultaneous events: TABLE_READY and T2MI_SOP in the same IDLE cycle: table wins and the T2-MI byte is not accepted (READY=0).
- Simultaneous events: TABLE_SENT together with a final TABLE_ENA byte: the byte is forwarded first, then the state changes.
- Counter widths: byte_cnt is 8 bits and never exceeds PKT_LEN. The timeout counter is 16 bits and saturates.

Optional Feature:
- Macro: NULL_PACKET_EN.
- With the macro defined: an idle counter runs in IDLE and clears on any accepted byte or any state exit.
- At NULL_GAP, go to NULL and emit one null packet: 0x47, 0x1F, 0xFF, 0x10, then 184 bytes of 0xFF, with ENA_OUT=1 every cycle and SOP_OUT on byte 0.
- During NULL, T2MI_READY=0. TABLE_READY is held off until the null packet completes, then return to IDLE.
- Without the macro: state NULL is unreachable and ENA_OUT stays low whenever there is no input.

Decomposition:
- Shared constants go in defines.v: PKT_LEN, SYNC_BYTE 0x47, NULL_PID 0x1FFF, and the mux state encodings (reused by state_mon decoding).
- Sub-module null_pkt_gen: a byte counter plus a header ROM. It is instantiated only under NULL_PACKET_EN and gives start/busy/data/ena to the mux.

Test Plan:
- Back-to-back T2-MI packets, READY always used, no table: DATA_OUT matches input delayed by 1 cycle; SOP_OUT every 188 bytes; PKT_ERR never set.
- TABLE_READY raised mid T2-MI packet (byte 90): the packet completes all 188 bytes; then TABLE_START pulses once; T2MI_READY=0 until TABLE_SENT; table bytes are forwarded in order.
- TABLE_READY and T2MI_SOP in the same IDLE cycle: TABLE_START=1, T2MI_READY=0; the T2-MI packet follows the 188-byte table packet intact.
- T2MI_SOP asserted at byte 100 of a packet: PKT_ERR pulses once; a new packet starts with SOP_OUT; the 100-byte truncated packet has been emitted.
- TABLE_START issued with TABLE_SENT withheld: after 1024 cycles the FSM returns to IDLE, PKT_ERR pulses, and T2MI_READY goes back to 1.
- NULL_PACKET_EN defined, no input for 4096 cycles: 188 bytes 47 1F FF 10 FF… with SOP_OUT on the first; TABLE_READY raised at byte 50 is served right after.

Source files
------------

// File: rtl/ts_table_mux_pkg.sv
// Shared constants, state encoding and the null-packet header ROM for the TS table mux.
// The state encoding is also what state_mon reports.
package ts_table_mux_pkg;

  localparam int          TS_PKT_LEN = 188;
  localparam logic [7:0]  SYNC_BYTE  = 8'h47;
  localparam logic [12:0] NULL_PID   = 13'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_T2MI  = 2'd1,
    ST_TABLE = 2'd2,
    ST_NULL  = 2'd3
  } mux_state_t;

  // Null packet: sync, PID 0x1FFF with no flags, payload-only AFC, CC 0, then 0xFF stuffing.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = SYNC_BYTE;
      8'd1:    b = {3'b000, NULL_PID[12:8]};
      8'd2:    b = NULL_PID[7:0];
      8'd3:    b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_table_mux_null_pkt_gen.sv
// Null TS packet generator (byte counter + header ROM); only built when NULL_PACKET_EN is defined.
// A start pulse emits one full packet, one byte per cycle, with busy high throughout.
`ifdef NULL_PACKET_EN
module ts_table_mux_null_pkt_gen
  import ts_table_mux_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       busy,
  output logic [7:0] data,
  output logic       ena,
  output logic       sop,
  output logic       last
);

  localparam logic [7:0] PKT_LAST_B = 8'(PKT_LEN - 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy <= 1'b0;
      cnt  <= 8'd0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= 8'd0;
    end else if (busy) begin
      if (cnt == PKT_LAST_B) busy <= 1'b0;
      else                   cnt  <= cnt + 8'd1;
    end
  end

  assign data = null_byte(cnt);
  assign ena  = busy;
  assign sop  = busy && (cnt == 8'd0);
  assign last = busy && (cnt == PKT_LAST_B);

endmodule
`endif

// File: rtl/ts_table_mux.sv
// Merges insert_tables PSI packets with the T2-MI TS stream, switching only at packet boundaries.
// Define NULL_PACKET_EN to emit a null packet after NULL_GAP idle cycles.
module ts_table_mux
  import ts_table_mux_pkg::*;
#(
  parameter int PKT_LEN       = TS_PKT_LEN,
  parameter int TABLE_TIMEOUT = 1024,
  parameter int NULL_GAP      = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] T2MI_DATA,
  input  logic       T2MI_ENA,
  input  logic       T2MI_SOP,
  output logic       T2MI_READY,
  input  logic       TABLE_READY,
  input  logic [7:0] TABLE_DATA,
  input  logic       TABLE_ENA,
  input  logic       TABLE_SENT,
  output logic       TABLE_START,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       SOP_OUT,
  output logic       PKT_ERR,
  output logic [1:0] state_mon
);

  localparam logic [7:0]  PKT_LEN_B = 8'(PKT_LEN);
  localparam logic [15:0] TO_LAST   = 16'(TABLE_TIMEOUT - 1);

  mux_state_t  state, state_nxt;
  logic [7:0]  byte_cnt, byte_cnt_nxt, byte_cnt_inc;
  logic [15:0] to_cnt, to_cnt_nxt;
  logic        run;
  logic        t2mi_rdy, t2mi_acc;
  logic [7:0]  data_nxt;
  logic        ena_nxt, sop_nxt, err_nxt, start_nxt;

`ifdef NULL_PACKET_EN
  localparam logic [15:0] IDLE_LAST = 16'(NULL_GAP - 1);
  logic [15:0] idle_cnt, idle_cnt_nxt;
  logic        null_start, null_busy, null_ena, null_sop, null_last;
  logic [7:0]  null_data;

  ts_table_mux_null_pkt_gen #(.PKT_LEN(PKT_LEN)) u_null_gen (
    .CLK   (CLK),
    .RST   (RST),
    .start (null_start),
    .busy  (null_busy),
    .data  (null_data),
    .ena   (null_ena),
    .sop   (null_sop),
    .last  (null_last)
  );
`else
  logic unused_null_gap;
  assign unused_null_gap = (NULL_GAP != 0);
`endif

  // run keeps READY low until the first clock after reset; a pending table blocks T2-MI in IDLE.
  assign t2mi_rdy = run && ((state == ST_T2MI) || ((state == ST_IDLE) && !TABLE_READY));
  assign t2mi_acc = T2MI_ENA && t2mi_rdy;
  assign byte_cnt_inc = (byte_cnt == PKT_LEN_B) ? byte_cnt : byte_cnt + 8'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    to_cnt_nxt   = to_cnt;
    data_nxt     = DATA_OUT;
    ena_nxt      = 1'b0;
    sop_nxt      = 1'b0;
    err_nxt      = 1'b0;
    start_nxt    = 1'b0;
`ifdef NULL_PACKET_EN
    null_start   = 1'b0;
    idle_cnt_nxt = 16'd0;
`endif
    case (state)
      ST_IDLE: begin
        byte_cnt_nxt = 8'd0;
        to_cnt_nxt   = 16'd0;
        if (TABLE_READY) begin
          start_nxt = 1'b1;
          state_nxt = ST_TABLE;
        end else if (t2mi_acc) begin
          if (T2MI_SOP) begin
            data_nxt     = T2MI_DATA;
            ena_nxt      = 1'b1;
            sop_nxt      = 1'b1;
            byte_cnt_nxt = 8'd1;
            state_nxt    = ST_T2MI;
          end else begin
            err_nxt = 1'b1;
          end
        end
`ifdef NULL_PACKET_EN
        else if (idle_cnt == IDLE_LAST) begin
          null_start = 1'b1;
          state_nxt  = ST_NULL;
        end else begin
          idle_cnt_nxt = idle_cnt + 16'd1;
        end
`endif
      end
      ST_T2MI: begin
        if (t2mi_acc) begin
          data_nxt = T2MI_DATA;
          ena_nxt  = 1'b1;
          if (T2MI_SOP) begin
            // The truncated packet has already gone out; this byte opens the next one.
            sop_nxt      = 1'b1;
            err_nxt      = 1'b1;
            byte_cnt_nxt = 8'd1;
          end else begin
            byte_cnt_nxt = byte_cnt_inc;
            if (byte_cnt_inc == PKT_LEN_B) state_nxt = ST_IDLE;
          end
        end
      end
      ST_TABLE: begin
        to_cnt_nxt = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
        if (TABLE_ENA) begin
          data_nxt     = TABLE_DATA;
          ena_nxt      = 1'b1;
          sop_nxt      = (byte_cnt == 8'd0);
          byte_cnt_nxt = byte_cnt_inc;
        end
        // The length test uses the updated count so a final byte alongside SENT is included.
        if (TABLE_SENT) begin
          state_nxt = ST_IDLE;
          err_nxt   = (byte_cnt_nxt != PKT_LEN_B);
        end else if (to_cnt >= TO_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
`ifdef NULL_PACKET_EN
      ST_NULL: begin
        data_nxt = null_data;
        ena_nxt  = null_ena;
        sop_nxt  = null_sop;
        if (null_last || !null_busy) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      byte_cnt    <= 8'd0;
      to_cnt      <= 16'd0;
      run         <= 1'b0;
      DATA_OUT    <= 8'd0;
      ENA_OUT     <= 1'b0;
      SOP_OUT     <= 1'b0;
      PKT_ERR     <= 1'b0;
      TABLE_START <= 1'b0;
`ifdef NULL_PACKET_EN
      idle_cnt    <= 16'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      run         <= 1'b1;
      DATA_OUT    <= data_nxt;
      ENA_OUT     <= ena_nxt;
      SOP_OUT     <= sop_nxt;
      PKT_ERR     <= err_nxt;
      TABLE_START <= start_nxt;
`ifdef NULL_PACKET_EN
      idle_cnt    <= idle_cnt_nxt;
`endif
    end
  end

  assign T2MI_READY = t2mi_rdy;
  assign state_mon  = state;

endmodule

// File: tb/tb_ts_table_mux.sv
// Self-checking bench for ts_table_mux: IDLE vector table, scoreboarded packet scenarios,
// table arbitration, truncation and table timeout corner cases.
module tb_ts_table_mux;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] T2MI_DATA = 8'd0;
  logic       T2MI_ENA = 1'b0;
  logic       T2MI_SOP = 1'b0;
  logic       T2MI_READY;
  logic       TABLE_READY = 1'b0;
  logic [7:0] TABLE_DATA = 8'd0;
  logic       TABLE_ENA = 1'b0;
  logic       TABLE_SENT = 1'b0;
  logic       TABLE_START;
  logic [7:0] DATA_OUT;
  logic       ENA_OUT;
  logic       SOP_OUT;
  logic       PKT_ERR;
  logic [1:0] state_mon;

  ts_table_mux dut (
    .CLK         (CLK),
    .RST         (RST),
    .T2MI_DATA   (T2MI_DATA),
    .T2MI_ENA    (T2MI_ENA),
    .T2MI_SOP    (T2MI_SOP),
    .T2MI_READY  (T2MI_READY),
    .TABLE_READY (TABLE_READY),
    .TABLE_DATA  (TABLE_DATA),
    .TABLE_ENA   (TABLE_ENA),
    .TABLE_SENT  (TABLE_SENT),
    .TABLE_START (TABLE_START),
    .DATA_OUT    (DATA_OUT),
    .ENA_OUT     (ENA_OUT),
    .SOP_OUT     (SOP_OUT),
    .PKT_ERR     (PKT_ERR),
    .state_mon   (state_mon)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       ena;
    logic       sop;
    logic [7:0] data;
    logic       exp_rdy;
    logic       exp_err;
    logic       exp_ena;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  int   sop_cnt = 0;
  int   start_cnt = 0;
  bit   sb_bypass = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: every ENA_OUT byte must match the next scoreboard entry, one cycle after input.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (ENA_OUT && !sb_bypass) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got byte 0x%0h with nothing queued (t=%0t)", DATA_OUT, $time);
          end else begin
            e = sb.pop_front();
            check("sb_data", DATA_OUT, e.data);
            check("sb_sop", SOP_OUT, e.sop);
            check("sb_latency", cyc, e.cyc);
          end
        end
        if (PKT_ERR) err_cnt++;
        if (ENA_OUT && SOP_OUT) sop_cnt++;
        if (TABLE_START) start_cnt++;
      end
    end
  end

  // Call right after a negedge; holds each byte until READY and queues it on acceptance.
  task automatic send_pkt(input int len, input int raise_tr_at);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      int         w;
      d = (i == 0) ? 8'h47 : 8'($urandom);
      T2MI_DATA = d;
      T2MI_SOP  = (i == 0);
      T2MI_ENA  = 1'b1;
      if (i == raise_tr_at) TABLE_READY = 1'b1;
      #1;
      w = 0;
      while (!T2MI_READY && w < 3000) begin
        @(negedge CLK);
        #1;
        w++;
      end
      if (!T2MI_READY) begin
        check("t2mi_ready_wait", 0, 1);
        T2MI_ENA = 1'b0;
        return;
      end
      sb.push_back('{d, (i == 0), cyc + 1});
      @(negedge CLK);
    end
    T2MI_ENA = 1'b0;
    T2MI_SOP = 1'b0;
  endtask

  // insert_tables model: waits for START, sends n bytes (optional one-cycle gap), then SENT.
  task automatic send_table(input int n, input bit sent_with_last, input int gap_at);
    int w = 0;
    int viol = 0;
    while (!TABLE_START && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    if (!TABLE_START) begin
      check("table_start_wait", 0, 1);
      TABLE_READY = 1'b0;
      return;
    end
    TABLE_READY = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      if (i == gap_at) begin
        TABLE_ENA = 1'b0;
        @(negedge CLK);
      end
      d = 8'($urandom);
      TABLE_DATA = d;
      TABLE_ENA  = 1'b1;
      TABLE_SENT = sent_with_last && (i == n - 1);
      sb.push_back('{d, (i == 0), cyc + 1});
      #1;
      if (T2MI_READY) viol++;
      @(negedge CLK);
    end
    TABLE_ENA = 1'b0;
    if (!sent_with_last) begin
      TABLE_SENT = 1'b1;
      @(negedge CLK);
    end
    TABLE_SENT = 1'b0;
    check("ready_low_in_table", viol, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   e0, s0, st0, n, w;

    // IDLE handshake vectors: non-SOP bytes are accepted, dropped and flagged.
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h47, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h47, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge CLK);
    check("rst_data", DATA_OUT, 8'h00);
    check("rst_ena", ENA_OUT, 1'b0);
    check("rst_sop", SOP_OUT, 1'b0);
    check("rst_ready", T2MI_READY, 1'b0);
    check("rst_start", TABLE_START, 1'b0);
    check("rst_err", PKT_ERR, 1'b0);
    check("rst_state", state_mon, 2'd0);
    RST = 1'b1;
    @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      T2MI_ENA  = vecs[v].ena;
      T2MI_SOP  = vecs[v].sop;
      T2MI_DATA = vecs[v].data;
      #1;
      check("vec_ready", T2MI_READY, vecs[v].exp_rdy);
      @(negedge CLK);
      check("vec_err", PKT_ERR, vecs[v].exp_err);
      check("vec_ena", ENA_OUT, vecs[v].exp_ena);
      check("vec_state", state_mon, 2'd0);
    end
    T2MI_ENA = 1'b0;
    T2MI_SOP = 1'b0;

    // Back-to-back T2-MI packets, no tables.
    e0 = err_cnt; s0 = sop_cnt;
    repeat (3) send_pkt(188, -1);
    repeat (3) @(negedge CLK);
    check("b2b_err", err_cnt - e0, 0);
    check("b2b_sops", sop_cnt - s0, 3);

    // TABLE_READY at byte 90: packet completes, then the table, then the held packet.
    e0 = err_cnt; s0 = sop_cnt; st0 = start_cnt;
    fork
      begin
        send_pkt(188, 90);
        send_pkt(188, -1);
      end
      send_table(188, 1'b0, 120);
    join
    repeat (3) @(negedge CLK);
    #1;
    check("mid_ready_back", T2MI_READY, 1'b1);
    check("mid_start_once", start_cnt - st0, 1);
    check("mid_err", err_cnt - e0, 0);
    check("mid_sops", sop_cnt - s0, 3);

    // TABLE_READY and T2MI_SOP together in IDLE: table wins, SENT with the last byte.
    @(negedge CLK);
    e0 = err_cnt; s0 = sop_cnt; st0 = start_cnt;
    TABLE_READY = 1'b1;
    T2MI_DATA = 8'h47; T2MI_SOP = 1'b1; T2MI_ENA = 1'b1;
    #1;
    check("tie_ready_low", T2MI_READY, 1'b0);
    fork
      send_pkt(188, -1);
      send_table(188, 1'b1, -1);
    join
    repeat (3) @(negedge CLK);
    check("tie_start_once", start_cnt - st0, 1);
    check("tie_err", err_cnt - e0, 0);
    check("tie_sops", sop_cnt - s0, 2);

    // SOP at byte 100: truncated packet goes out, error pulses once, new packet starts.
    e0 = err_cnt; s0 = sop_cnt;
    send_pkt(100, -1);
    send_pkt(188, -1);
    repeat (3) @(negedge CLK);
    check("trunc_err", err_cnt - e0, 1);
    check("trunc_sops", sop_cnt - s0, 2);

    // Table timeout: START with no SENT returns to IDLE after TABLE_TIMEOUT cycles.
    e0 = err_cnt; st0 = start_cnt;
    TABLE_READY = 1'b1;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!TABLE_START && w < 10);
    check("to_start", TABLE_START, 1'b1);
    TABLE_READY = 1'b0;
    n = 0;
    while (!PKT_ERR && n < 2000) begin
      @(negedge CLK);
      n++;
      if (n == 500) begin
        check("to_state_table", state_mon, 2'd2);
        check("to_ready_low", T2MI_READY, 1'b0);
      end
    end
    check("to_cycles", n, 1024);
    #1;
    check("to_ready_back", T2MI_READY, 1'b1);
    check("to_state_idle", state_mon, 2'd0);
    @(negedge CLK);
    TABLE_DATA = 8'h5A; TABLE_ENA = 1'b1;
    @(negedge CLK);
    TABLE_ENA = 1'b0;
    check("to_stray_ignored", ENA_OUT, 1'b0);
    repeat (2) @(negedge CLK);
    check("to_err_once", err_cnt - e0, 1);
    check("to_start_once", start_cnt - st0, 1);

    // Short table (10 bytes) then SENT: length error.
    e0 = err_cnt;
    TABLE_READY = 1'b1;
    send_table(10, 1'b0, -1);
    repeat (3) @(negedge CLK);
    check("short_table_err", err_cnt - e0, 1);

`ifdef NULL_PACKET_EN
    // Idle gap produces a null packet; a table raised mid-packet is served right after it.
    sb_bypass = 1'b1;
    w = 0;
    while (!ENA_OUT && w < 5000) begin
      @(negedge CLK);
      w++;
    end
    check("null_seen", ENA_OUT, 1'b1);
    for (int i = 0; i < 188; i++) begin
      logic [7:0] eb;
      eb = (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 3) ? 8'h10 : 8'hFF;
      check("null_ena", ENA_OUT, 1'b1);
      check("null_data", DATA_OUT, eb);
      check("null_sop", SOP_OUT, (i == 0));
      if (i == 50) TABLE_READY = 1'b1;
      @(negedge CLK);
    end
    sb_bypass = 1'b0;
    check("null_then_table", TABLE_START, 1'b1);
    send_table(188, 1'b1, -1);
    repeat (3) @(negedge CLK);
`else
    // Without the null feature the output stays quiet while idle.
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (ENA_OUT || state_mon != 2'd0) n++;
    end
    check("idle_quiet", n, 0);
`endif

    repeat (5) @(negedge CLK);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
